// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes used by the CPU core's ALU and the
// state encoding of the sequencing divider that borrows it.
package alu_pkg;

  localparam logic [5:0] ALU_SEL_ADD  = 6'h20;
  localparam logic [5:0] ALU_SEL_SUB  = 6'h21;
  localparam logic [5:0] ALU_SEL_AND  = 6'h24;
  localparam logic [5:0] ALU_SEL_OR   = 6'h25;
  localparam logic [5:0] ALU_SEL_XOR  = 6'h26;
  localparam logic [5:0] ALU_SEL_NOR  = 6'h27;
  localparam logic [5:0] ALU_SEL_SLT  = 6'h2a;
  localparam logic [5:0] ALU_SEL_SLTU = 6'h2b;
  localparam logic [5:0] ALU_SEL_BT   = 6'h2c;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    SUB,
    FIXUP,
    DONE
  } div_state_t;

endpackage

// File: rtl/alu_div_seq_if.sv
// Bundle of the divider's request/result signals and its borrowed-ALU port.
// signed_op exists only when ALU_DIV_SIGNED_EN is defined.
interface alu_div_seq_if #(parameter int WIDTH = 16);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef ALU_DIV_SIGNED_EN
  logic             signed_op;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             alu_req;
  logic             alu_gnt;
  logic [5:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;

  modport master (
    output start, dividend, divisor,
`ifdef ALU_DIV_SIGNED_EN
    output signed_op,
`endif
    output alu_gnt, alu_out,
    input  busy, done, quotient, remainder, div_by_zero,
    input  alu_req, alu_sel, alu_a, alu_b
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef ALU_DIV_SIGNED_EN
    input  signed_op,
`endif
    input  alu_gnt, alu_out,
    output busy, done, quotient, remainder, div_by_zero,
    output alu_req, alu_sel, alu_a, alu_b
  );

endinterface

// File: rtl/alu_div_seq_sign_fix.sv
// Sign handling for signed division (used only under ALU_DIV_SIGNED_EN):
// operand magnitudes at start, result negation after the unsigned core.
module alu_div_sign_fix #(parameter int WIDTH = 16) (
  input  logic             i_signedOp,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_dividendMag,
  output logic [WIDTH-1:0] o_divisorMag,
  output logic             o_negQuo,
  output logic             o_negRem,
  input  logic             i_negQuo,
  input  logic             i_negRem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_rem,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem
);

  logic w_dividendNeg;
  logic w_divisorNeg;

  assign w_dividendNeg = i_signedOp & i_dividend[WIDTH-1];
  assign w_divisorNeg  = i_signedOp & i_divisor[WIDTH-1];

  // The most negative value maps onto itself, which reads correctly as unsigned
  assign o_dividendMag = w_dividendNeg ? -i_dividend : i_dividend;
  assign o_divisorMag  = w_divisorNeg  ? -i_divisor  : i_divisor;

  assign o_negQuo = w_dividendNeg ^ w_divisorNeg;
  assign o_negRem = w_dividendNeg;

  assign o_quo = i_negQuo ? -i_quo : i_quo;
  assign o_rem = i_negRem ? -i_rem : i_rem;

endmodule

// File: rtl/alu_div_seq.sv
// Restoring divider that borrows the shared ALU (BT to compare, SUB to subtract).
// Define ALU_DIV_SIGNED_EN to add signed_op and a one-cycle FIXUP state.
module alu_div_seq
  import alu_pkg::*;
#(parameter int WIDTH = 16) (
  input logic          clk,
  input logic          rst_n,
  alu_div_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_rsh;
  logic             r_ovf;
  logic             r_ge;
  logic [WIDTH-1:0] r_div;
  logic             r_aluReq;
  logic [5:0]       r_aluSel;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dz;

  logic [WIDTH-1:0] w_dividendMag;
  logic [WIDTH-1:0] w_divisorMag;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_quoNext;

`ifdef ALU_DIV_SIGNED_EN
  logic             r_negQuo;
  logic             r_negRem;
  logic             w_negQuo;
  logic             w_negRem;
  logic [WIDTH-1:0] w_fixQuo;
  logic [WIDTH-1:0] w_fixRem;

  alu_div_sign_fix #(.WIDTH(WIDTH)) u_signFix (
    .i_signedOp    (bus.signed_op),
    .i_dividend    (bus.dividend),
    .i_divisor     (bus.divisor),
    .o_dividendMag (w_dividendMag),
    .o_divisorMag  (w_divisorMag),
    .o_negQuo      (w_negQuo),
    .o_negRem      (w_negRem),
    .i_negQuo      (r_negQuo),
    .i_negRem      (r_negRem),
    .i_quo         (r_quo),
    .i_rem         (r_rem),
    .o_quo         (w_fixQuo),
    .o_rem         (w_fixRem)
  );
`else
  assign w_dividendMag = bus.dividend;
  assign w_divisorMag  = bus.divisor;
`endif

  // A wrapped SUB result is still the right remainder when the shift overflowed
  assign w_remNext = r_ge ? bus.alu_out : r_rsh;
  assign w_quoNext = {r_quo[WIDTH-2:0], r_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_rsh       <= '0;
      r_ovf       <= 1'b0;
      r_ge        <= 1'b0;
      r_div       <= '0;
      r_aluReq    <= 1'b0;
      r_aluSel    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dz        <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
      r_negQuo    <= 1'b0;
      r_negRem    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dz        <= 1'b1;
            end else begin
              r_state  <= CMP;
              r_busy   <= 1'b1;
              r_dz     <= 1'b0;
              r_aluReq <= 1'b1;
              r_aluSel <= ALU_SEL_BT;
              r_div    <= w_divisorMag;
              r_quo    <= w_dividendMag;
              r_rem    <= '0;
              r_rsh    <= {{(WIDTH-1){1'b0}}, w_dividendMag[WIDTH-1]};
              r_ovf    <= 1'b0;
              r_cnt    <= CNT_INIT;
`ifdef ALU_DIV_SIGNED_EN
              r_negQuo <= w_negQuo;
              r_negRem <= w_negRem;
`endif
            end
          end
        end
        CMP: begin
          if (bus.alu_gnt) begin
            r_ge     <= r_ovf | ~bus.alu_out[0];
            r_state  <= SUB;
            r_aluSel <= ALU_SEL_SUB;
          end
        end
        SUB: begin
          if (bus.alu_gnt) begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_aluReq <= 1'b0;
              r_aluSel <= '0;
              r_div    <= '0;
              r_rsh    <= '0;
`ifdef ALU_DIV_SIGNED_EN
              r_state  <= FIXUP;
`else
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_quotient  <= w_quoNext;
              r_remainder <= w_remNext;
`endif
            end else begin
              r_state  <= CMP;
              r_aluSel <= ALU_SEL_BT;
              r_rsh    <= {w_remNext[WIDTH-2:0], w_quoNext[WIDTH-1]};
              r_ovf    <= w_remNext[WIDTH-1];
            end
          end
        end
`ifdef ALU_DIV_SIGNED_EN
        FIXUP: begin
          r_state     <= DONE;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_quotient  <= w_fixQuo;
          r_remainder <= w_fixRem;
        end
`endif
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dz;
  assign bus.alu_req     = r_aluReq;
  assign bus.alu_sel     = r_aluSel;
  assign bus.alu_a       = r_div;
  assign bus.alu_b       = r_rsh;

endmodule

// File: tb/tb_alu_div_seq.sv
// Bench for alu_div_seq: reference ALU, grant schedule table, scoreboard of
// expected results computed with plain integer division.
module tb_alu_div_seq;
  import alu_pkg::*;

  localparam int W     = 16;
  localparam int TABSZ = 8192;
`ifdef ALU_DIV_SIGNED_EN
  localparam int FIXCYC    = 1;
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam int FIXCYC    = 0;
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           doneCyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  alu_div_seq_if #(.WIDTH(W)) bus();

  alu_div_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t         sb[$];
  int           cyc       = 0;
  int           nChecks   = 0;
  int           nFails    = 0;
  int           freeCycle = 0;
  bit           gntTab[TABSZ];
  logic [W-1:0] noise = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [W-1:0] aluRef(input logic [5:0] sel, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (sel)
      ALU_SEL_ADD: return a + b;
      ALU_SEL_SUB: return b - a;
      ALU_SEL_AND: return a & b;
      ALU_SEL_OR:  return a | b;
      ALU_SEL_XOR: return a ^ b;
      ALU_SEL_BT:  return (b < a) ? W'(1) : W'(0);
      default:     return '0;
    endcase
  endfunction

  // While the core owns the ALU the divider sees unrelated traffic
  always_comb bus.alu_out = bus.alu_gnt ? aluRef(bus.alu_sel, bus.alu_a, bus.alu_b) : noise;

  initial begin
    bus.alu_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.alu_gnt = (cyc < TABSZ) ? gntTab[cyc] : 1'b1;
      noise = W'($urandom);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                 input bit sgn, input int s);
    exp_t e;
    int   c;
    int   need;
    int   a;
    int   b;
    if (dv == '0) begin
      e.q = '1;
      e.r = dd;
      e.dz = 1'b1;
      e.doneCyc = s + 1;
      return e;
    end
    if (sgn) begin
      a = int'($signed(dd));
      b = int'($signed(dv));
    end else begin
      a = int'(dd);
      b = int'(dv);
    end
    e.q = W'(a / b);
    e.r = W'(a % b);
    e.dz = 1'b0;
    c = s + 1;
    need = 2 * W;
    while (need > 0 && c < TABSZ) begin
      if (gntTab[c]) need--;
      c++;
    end
    e.doneCyc = c + FIXCYC;
    return e;
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit sgn);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
`ifdef ALU_DIV_SIGNED_EN
    bus.signed_op = sgn;
`endif
    if (rst_n && cyc >= freeCycle) begin
      e = model(dd, dv, sgn && SIGNED_EN, cyc);
      sb.push_back(e);
      freeCycle = e.doneCyc + 1;
    end
    waitCycles(1);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
  endtask

  task automatic waitFree();
    while (cyc < freeCycle) waitCycles(1);
    checkOutput("scoreboardDrained", sb.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Busy"}, 32'(bus.busy), 0);
    checkOutput({tag, "Done"}, 32'(bus.done), 0);
    checkOutput({tag, "Quotient"}, 32'(bus.quotient), 0);
    checkOutput({tag, "Remainder"}, 32'(bus.remainder), 0);
    checkOutput({tag, "Dz"}, 32'(bus.div_by_zero), 0);
    checkOutput({tag, "AluReq"}, 32'(bus.alu_req), 0);
    checkOutput({tag, "AluSel"}, 32'(bus.alu_sel), 0);
    checkOutput({tag, "AluA"}, 32'(bus.alu_a), 0);
    checkOutput({tag, "AluB"}, 32'(bus.alu_b), 0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedDone", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("quotient", 32'(bus.quotient), 32'(e.q));
          checkOutput("remainder", 32'(bus.remainder), 32'(e.r));
          checkOutput("divByZero", 32'(bus.div_by_zero), 32'(e.dz));
          checkOutput("doneCycle", cyc, e.doneCyc);
          checkOutput("busyAtDone", 32'(bus.busy), 0);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] dd;
    logic [W-1:0] dv;
    bit           sgn;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef ALU_DIV_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    for (int i = 0; i < TABSZ; i++) gntTab[i] = 1'b1;
    rst_n = 1'b0;
    waitCycles(3);
    checkAllZero("reset");
    rst_n = 1'b1;
    waitCycles(1);
    freeCycle = cyc;

    $display("[TB] basic 100/7");
    applyStimulus(16'd100, 16'd7, 1'b0);
    checkOutput("t1BusyFirst", 32'(bus.busy), 1);
    checkOutput("t1Req", 32'(bus.alu_req), 1);
    checkOutput("t1SelBt", 32'(bus.alu_sel), 32'(ALU_SEL_BT));
    checkOutput("t1AluA", 32'(bus.alu_a), 7);
    checkOutput("t1AluB", 32'(bus.alu_b), 0);
    waitCycles(1);
    checkOutput("t1SelSub", 32'(bus.alu_sel), 32'(ALU_SEL_SUB));
    waitCycles(2 * W + FIXCYC - 2);
    checkOutput("t1BusyLast", 32'(bus.busy), 1);
    waitCycles(1);
    checkOutput("t1BusyDropped", 32'(bus.busy), 0);
    waitFree();

    $display("[TB] overflow path and divide by one");
    applyStimulus(16'hFFFF, 16'h8000, 1'b0);
    waitFree();
    applyStimulus(16'h1234, 16'h0001, 1'b0);
    waitFree();

    $display("[TB] divide by zero");
    applyStimulus(16'd5, 16'd0, 1'b0);
    waitFree();
    checkOutput("t3DzHeld", 32'(bus.div_by_zero), 1);
    applyStimulus(16'd100, 16'd7, 1'b0);
    checkOutput("t3DzCleared", 32'(bus.div_by_zero), 0);
    waitFree();

    $display("[TB] grant withheld for 5 cycles");
    for (int k = 10; k < 15; k++) gntTab[cyc + k] = 1'b0;
    applyStimulus(16'd100, 16'd7, 1'b0);
    waitCycles(11);
    checkOutput("t4ReqHeld", 32'(bus.alu_req), 1);
    checkOutput("t4BusyHeld", 32'(bus.busy), 1);
    checkOutput("t4AluAHeld", 32'(bus.alu_a), 7);
    waitFree();

    $display("[TB] ignored start, then reset mid-operation");
    applyStimulus(16'd1000, 16'd3, 1'b0);
    waitCycles(3);
    applyStimulus(16'd9, 16'd9, 1'b0);
    waitCycles(7);
    rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    sb.delete();
    waitCycles(1);
    rst_n = 1'b1;
    freeCycle = cyc;
    waitCycles(40);
    applyStimulus(16'd1000, 16'd3, 1'b0);
    waitFree();

`ifdef ALU_DIV_SIGNED_EN
    $display("[TB] signed operations");
    applyStimulus(16'hFFF9, 16'd2, 1'b1);
    waitFree();
    applyStimulus(16'd7, 16'd2, 1'b0);
    waitFree();
    applyStimulus(16'h8000, 16'hFFFF, 1'b1);
    waitFree();
    applyStimulus(16'hFFF9, 16'd0, 1'b1);
    waitFree();
`endif

    $display("[TB] randomized operations with random grant stalls");
    for (int n = 0; n < 60; n++) begin
      dd = W'($urandom);
      case ($urandom_range(0, 7))
        0:       dv = '0;
        1, 2:    dv = W'($urandom_range(1, 15));
        3:       dv = 16'hFFFF;
        default: dv = W'($urandom);
      endcase
      sgn = SIGNED_EN && ($urandom_range(0, 1) == 1);
      for (int k = 1; k <= 2 * W + 8; k++)
        if (cyc + k < TABSZ) gntTab[cyc + k] = ($urandom_range(0, 3) != 0);
      applyStimulus(dd, dv, sgn);
      waitFree();
      waitCycles($urandom_range(0, 2));
    end

    waitCycles(5);
    checkOutput("finalDrained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
